// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch stage.
// Optional feature macro: IFETCH_HALT_DETECT_EN (halt on all-ones instruction word).
package ifetch_pkg;

    localparam int unsigned ADDR_W_DEF = 7;
    localparam int unsigned DATA_W_DEF = 32;
    localparam logic [31:0] HALT_WORD  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } state_t;

endpackage

// File: rtl/ifetch_loader.sv
// ifetch_loader: program-image write side of the fetch stage.
// Holds the load word counter, produces the memory write strobe/address and
// a done pulse on the final accepted word (load_last or the top address).
module ifetch_loader
    import ifetch_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              active,
    input  logic              load_valid,
    input  logic              load_last,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic              done
);

    logic [ADDR_W-1:0] count;

    assign we   = active && load_valid;
    assign addr = count;
    assign done = we && (load_last || (count == '1));

    // Word counter: parked at zero outside LOAD so every load image starts at address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!active) begin
            count <= '0;
        end else if (we) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC/fetch stage in front of a 128x32 instruction memory.
// IDLE -> LOAD streams a program image into memory, then RUN fetches
// sequential words with zero-bubble branch redirect over a valid/ready port.
// Optional feature macro: IFETCH_HALT_DETECT_EN (all-ones word halts fetch).
module instruction_fetch
    import ifetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter int unsigned       DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              instr_ready,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              halted,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    inout  logic [DATA_W-1:0] mem_data
);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pend_pc;
    logic              pend_valid;
    logic [ADDR_W-1:0] hold_addr;

    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_done;

    logic              advance;
    logic              halt_hit;
    logic [ADDR_W-1:0] run_addr;

    ifetch_loader #(
        .ADDR_W (ADDR_W)
    ) u_loader (
        .clk        (clk),
        .rst_n      (rst_n),
        .active     (state == LOAD),
        .load_valid (load_valid),
        .load_last  (load_last),
        .we         (ld_we),
        .addr       (ld_addr),
        .done       (ld_done)
    );

`ifdef IFETCH_HALT_DETECT_EN
    assign halt_hit = (state == RUN) && pend_valid && (mem_data == DATA_W'(HALT_WORD));
    assign halted   = (state == HALT);
`else
    assign halt_hit = 1'b0;
    assign halted   = 1'b0;
`endif

    // The bus is only driven during a load write; the memory owns it otherwise.
    assign mem_data    = ld_we ? load_data : 'z;
    assign mem_we      = ld_we;
    assign load_ready  = (state == LOAD);
    assign instr_valid = (state == RUN) && pend_valid && !halt_hit;
    assign instr_pc    = pend_pc;
    assign instr_data  = mem_data;

    assign advance  = !pend_valid || instr_ready;
    assign run_addr = branch_taken ? branch_target : (advance ? pc : pend_pc);

    // Memory address select per state; on a stall the pending address is re-read.
    always_comb begin
        mem_addr = '0;
        case (state)
            IDLE:    mem_addr = '0;
            LOAD:    mem_addr = ld_addr;
            RUN:     mem_addr = run_addr;
            HALT:    mem_addr = hold_addr;
            default: mem_addr = '0;
        endcase
    end

    // Control FSM plus fetch PC and pending-instruction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            pend_pc    <= '0;
            pend_valid <= 1'b0;
            hold_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (ld_done) begin
                        state      <= RUN;
                        pc         <= RESET_PC;
                        pend_valid <= 1'b0;
                    end
                end
                RUN: begin
                    hold_addr <= run_addr;
                    if (load_start) begin
                        state      <= LOAD;
                        pend_valid <= 1'b0;
                    end else if (halt_hit && !branch_taken) begin
                        state      <= HALT;
                        pend_valid <= 1'b0;
                    end else if (branch_taken) begin
                        pc         <= branch_target + 1'b1;
                        pend_pc    <= branch_target;
                        pend_valid <= 1'b1;
                    end else if (advance) begin
                        pc         <= pc + 1'b1;
                        pend_pc    <= pc;
                        pend_valid <= 1'b1;
                    end
                end
                HALT: begin
                    if (load_start) begin
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
